// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  // Default widths, matching the team's 8-bit single-port RAM.
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 8;

  // Supported read-latency range of the RAM behind the arbiter.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Wide enough to hold RD_LAT_MAX-1.
  localparam int CNT_W = $clog2(RD_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t P0 = 1'b0;
  localparam port_id_t P1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Master-side bus of the RAM arbiter: two independent req/ack ports.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);

  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;

  // The two masters sharing the RAM.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1
  );

  // The arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the port that did not win last time.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t last_gnt,
  output logic     gnt_valid,
  output port_id_t gnt_id
);

  // Pick the winning port from the current requests and the previous winner.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = P0;
    if (req0 && req1) begin
      gnt_id = (last_gnt == P0) ? P1 : P0;
    end else if (req1) begin
      gnt_id = P1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer placing two masters in front of one
// single-port synchronous RAM. Every output is registered.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus,
  output logic          busy,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out
);

  // Out-of-range latencies are clamped so the counter can never overflow.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_t           state, state_d;
  port_id_t         last_gnt, last_gnt_d;
  port_id_t         gnt_id, gnt_id_d;
  port_id_t         pick_id;
  logic             pick_valid;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             ram_wr_d;
  logic [AW-1:0]    ram_addr_d;
  logic [DW-1:0]    ram_data_in_d;
  logic             ack0, ack1, ack0_d, ack1_d;
  logic [DW-1:0]    rdata0, rdata1, rdata0_d, rdata1_d;
  logic             busy_d;

  rr_arb2 u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last_gnt  (last_gnt),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  // Next state and next value of every registered output.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d       = state;
    last_gnt_d    = last_gnt;
    gnt_id_d      = gnt_id;
    cnt_d         = cnt;
    ram_wr_d      = 1'b0;
    ram_addr_d    = ram_addr;
    ram_data_in_d = ram_data_in;
    rdata0_d      = rdata0;
    rdata1_d      = rdata1;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          // ram_addr/ram_data_in double as the latched address and write data.
          gnt_id_d      = pick_id;
          last_gnt_d    = pick_id;
          ram_wr_d      = (pick_id == P0) ? bus.we0    : bus.we1;
          ram_addr_d    = (pick_id == P0) ? bus.addr0  : bus.addr1;
          ram_data_in_d = (pick_id == P0) ? bus.wdata0 : bus.wdata1;
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        // ram_wr still carries the latched write enable during this cycle.
        if (ram_wr) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          if (gnt_id == P0) rdata0_d = ram_data_out;
          else              rdata1_d = ram_data_out;
          state_d = RESP;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase

    // The ack register is set on entry to RESP so the pulse coincides with it.
    if (state_d == RESP) begin
      ack0_d = (gnt_id == P0);
      ack1_d = (gnt_id == P1);
    end
    busy_d = (state_d != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Datapath and output registers; reset also drops ram_wr asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt    <= P1;
      gnt_id      <= P0;
      cnt         <= '0;
      ram_wr      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      busy        <= 1'b0;
    end else begin
      last_gnt    <= last_gnt_d;
      gnt_id      <= gnt_id_d;
      cnt         <= cnt_d;
      ram_wr      <= ram_wr_d;
      ram_addr    <= ram_addr_d;
      ram_data_in <= ram_data_in_d;
      ack0        <= ack0_d;
      ack1        <= ack1_d;
      rdata0      <= rdata0_d;
      rdata1      <= rdata1_d;
      busy        <= busy_d;
    end
  end

  assign bus.ack0   = ack0;
  assign bus.ack1   = ack1;
  assign bus.rdata0 = rdata0;
  assign bus.rdata1 = rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM, per-port request queues, and a
// transaction-level reference (memory image, round-robin order, latencies).
`timescale 1ns/1ps
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int RD_LAT = 3;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy, ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in, ram_data_out;

  ram_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  ram_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .busy         (busy),
    .ram_wr       (ram_wr),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with RD_LAT cycles of read latency.
  logic [DW-1:0] ram_mem [2**AW];
  logic [DW-1:0] rd_pipe [RD_LAT];
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;

  always @(posedge clk) begin
    if (load_en)     ram_mem[load_addr] <= load_data;
    else if (ram_wr) ram_mem[ram_addr]  <= ram_data_in;
    rd_pipe[0] <= ram_mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_data_out = rd_pipe[RD_LAT-1];

  // Reference state.
  logic [DW-1:0] ref_mem [2**AW];
  op_t           q0[$], q1[$];
  port_id_t      exp_last;
  logic [DW-1:0] exp_rd0, exp_rd1;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.we = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       o.addr = '0;
      1:       o.addr = '1;
      default: o.addr = AW'($urandom);
    endcase
    o.wdata = DW'($urandom);
    return o;
  endfunction

  task automatic drive_reqs();
    bus.req0 = (q0.size() != 0);
    if (q0.size() != 0) begin
      bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].wdata;
    end
    bus.req1 = (q1.size() != 0);
    if (q1.size() != 0) begin
      bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].wdata;
    end
  endtask

  // Serve both queues from an IDLE cycle until empty; ends on the IDLE cycle
  // after the last ack with both requests low.
  task automatic run_queues(input string tag);
    op_t      cur;
    port_id_t gp;
    logic     p0, p1;
    int       ack_cyc;
    logic [3:0] ctl_exp;
    drive_reqs();
    while (q0.size() != 0 || q1.size() != 0) begin
      p0 = (q0.size() != 0);
      p1 = (q1.size() != 0);
      gp = (p0 && p1) ? ~exp_last : (p0 ? P0 : P1);
      exp_last = gp;
      cur = (gp == P0) ? q0[0] : q1[0];
      ack_cyc = cur.we ? 2 : 2 + RD_LAT;
      for (int c = 1; c <= ack_cyc; c++) begin
        tick();
        if (c == ack_cyc) begin
          if (cur.we)         ref_mem[cur.addr] = cur.wdata;
          else if (gp == P0)  exp_rd0 = ref_mem[cur.addr];
          else                exp_rd1 = ref_mem[cur.addr];
          if (gp == P0) void'(q0.pop_front());
          else          void'(q1.pop_front());
        end
        ctl_exp = {cur.we && c == 1, 1'b1, c == ack_cyc && gp == P0, c == ack_cyc && gp == P1};
        n_tests++;
        if ({ram_wr, busy, bus.ack0, bus.ack1} !== ctl_exp) begin
          n_fail++;
          $display("FAIL %s ctrl port%0d cyc%0d {wr,busy,ack0,ack1}: got %b want %b",
                   tag, gp, c, {ram_wr, busy, bus.ack0, bus.ack1}, ctl_exp);
        end
        n_tests++;
        if ({bus.rdata0, bus.rdata1} !== {exp_rd0, exp_rd1}) begin
          n_fail++;
          $display("FAIL %s rdata cyc%0d: got %h/%h want %h/%h",
                   tag, c, bus.rdata0, bus.rdata1, exp_rd0, exp_rd1);
        end
        if (c == 1) begin
          n_tests++;
          if (ram_addr !== cur.addr || (cur.we && ram_data_in !== cur.wdata)) begin
            n_fail++;
            $display("FAIL %s ram bus: got addr %h din %h want addr %h din %h",
                     tag, ram_addr, ram_data_in, cur.addr, cur.wdata);
          end
        end
      end
      drive_reqs();
      tick();
      n_tests++;
      if ({ram_wr, busy, bus.ack0, bus.ack1} !== 4'b0000) begin
        n_fail++;
        $display("FAIL %s idle {wr,busy,ack0,ack1}: got %b want 0000",
                 tag, {ram_wr, busy, bus.ack0, bus.ack1});
      end
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    for (int a = 0; a < 2**AW; a++) begin
      d = (a == 2**AW - 1) ? 8'hA5 : DW'($urandom);
      ref_mem[a] = d;
      load_en = 1'b1; load_addr = AW'(a); load_data = d;
      tick();
    end
    load_en = 1'b0;
    n_tests++;
    if ({ram_wr, busy, bus.ack0, bus.ack1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset ctrl: got %b want 0000", {ram_wr, busy, bus.ack0, bus.ack1});
    end
    n_tests++;
    if (ram_addr !== '0 || ram_data_in !== '0) begin
      n_fail++;
      $display("FAIL reset ram bus: got addr %h din %h want 00 00", ram_addr, ram_data_in);
    end
    n_tests++;
    if (bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
      n_fail++;
      $display("FAIL reset rdata: got %h/%h want 00/00", bus.rdata0, bus.rdata1);
    end
    rst_n = 1'b1;
    tick();
    exp_last = P1; exp_rd0 = '0; exp_rd1 = '0;
  endtask

  task automatic test_tie();
    q0.push_back(mk(1'b1, 8'd24, 8'h0F));
    q1.push_back(mk(1'b0, 8'd24, 8'h00));
    run_queues("tie");
    n_tests++;
    if (bus.rdata1 !== 8'h0F) begin
      n_fail++;
      $display("FAIL tie rdata1: got %h want 0f", bus.rdata1);
    end
  endtask

  task automatic test_write_read();
    q0.push_back(mk(1'b1, 8'd10, 8'h07));
    run_queues("wr10");
    q0.push_back(mk(1'b0, 8'd10, 8'h00));
    run_queues("rd10");
    n_tests++;
    if (bus.rdata0 !== 8'h07) begin
      n_fail++;
      $display("FAIL rd10 rdata0: got %h want 07", bus.rdata0);
    end
  endtask

  task automatic test_rd255();
    q1.push_back(mk(1'b0, 8'd255, 8'h00));
    run_queues("rd255");
    n_tests++;
    if (bus.rdata1 !== 8'hA5 || bus.rdata0 !== 8'h07) begin
      n_fail++;
      $display("FAIL rd255 rdata: got %h/%h want 07/a5", bus.rdata0, bus.rdata1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    run_queues("b2b");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < $urandom_range(0, 4); i++) q0.push_back(rand_op());
      for (int i = 0; i < $urandom_range(0, 4); i++) q1.push_back(rand_op());
      run_queues("rand");
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    // Abort a port-1 read while it waits on the RAM.
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = AW'($urandom);
    tick();
    tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait busy before reset: got %b want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ram_wr, busy, bus.ack0, bus.ack1, bus.rdata1} !== {4'b0000, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_wait outputs: got %b %h want 0000 00",
               {ram_wr, busy, bus.ack0, bus.ack1}, bus.rdata1);
    end
    bus.req1 = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if ({ram_wr, busy, bus.ack0, bus.ack1} !== 4'b0000) begin
        n_fail++;
        $display("FAIL rst_wait after release: got %b want 0000", {ram_wr, busy, bus.ack0, bus.ack1});
      end
    end
    // Abort a port-0 write in its ACCESS cycle: ram_wr must drop at once.
    a = AW'($urandom);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = a; bus.wdata0 = DW'($urandom);
    tick();
    n_tests++;
    if (ram_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_acc ram_wr before reset: got %b want 1", ram_wr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ram_wr !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_acc async drop: got wr %b busy %b want 0 0", ram_wr, busy);
    end
    bus.req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    // Whether the aborted write landed is unspecified; follow the RAM.
    ref_mem[a] = ram_mem[a];
    exp_last = P1; exp_rd0 = '0; exp_rd1 = '0;
    // First tie after reset goes to port 0.
    q0.push_back(rand_op());
    q1.push_back(rand_op());
    run_queues("rst_tie");
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if ({ram_wr, busy, bus.ack0, bus.ack1} !== 4'b0000 ||
          {bus.rdata0, bus.rdata1} !== {exp_rd0, exp_rd1}) begin
        n_fail++;
        $display("FAIL idle cyc%0d: got %b %h/%h want 0000 %h/%h", i,
                 {ram_wr, busy, bus.ack0, bus.ack1}, bus.rdata0, bus.rdata1, exp_rd0, exp_rd1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_write_read();
    test_rd255();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
